// File: rtl/divider_batch_engine_if.sv
// Control, memory-channel and divider signals of the batch-division engine.
// master is the engine side; slave is the CSR/memory/divider side.
interface divider_batch_engine_if #(
  parameter int DATA_LEN  = 32,
  parameter int CL_ADDR_W = 42,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic [CL_ADDR_W-1:0] in_base;
  logic [CL_ADDR_W-1:0] out_base;
  logic [CNT_W-1:0]     num_lines;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     div0_count;
  logic                 rd_req_valid;
  logic [CL_ADDR_W-1:0] rd_req_addr;
  logic                 rd_req_almost_full;
  logic                 rd_rsp_valid;
  logic [511:0]         rd_rsp_data;
  logic                 wr_req_valid;
  logic [CL_ADDR_W-1:0] wr_req_addr;
  logic [511:0]         wr_req_data;
  logic                 wr_req_almost_full;
  logic                 wr_rsp_valid;
  logic [DATA_LEN-1:0]  div_a;
  logic [DATA_LEN-1:0]  div_b;
  logic                 div_in_valid;
  logic [DATA_LEN-1:0]  div_result;

  modport master (
    input  start, in_base, out_base, num_lines,
    input  rd_req_almost_full, rd_rsp_valid, rd_rsp_data,
    input  wr_req_almost_full, wr_rsp_valid, div_result,
    output busy, done, div0_count,
    output rd_req_valid, rd_req_addr,
    output wr_req_valid, wr_req_addr, wr_req_data,
    output div_a, div_b, div_in_valid
  );

  modport slave (
    output start, in_base, out_base, num_lines,
    output rd_req_almost_full, rd_rsp_valid, rd_rsp_data,
    output wr_req_almost_full, wr_rsp_valid, div_result,
    input  busy, done, div0_count,
    input  rd_req_valid, rd_req_addr,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    input  div_a, div_b, div_in_valid
  );
endinterface

// File: rtl/divider_batch_engine.sv
// Streams operand lines through a pipelined divider and writes result lines.
// A tag pipeline matched to the divider latency routes results to lane slots.
module divider_batch_engine #(
  parameter int DATA_LEN    = 32,
  parameter int LANES       = 8,
  parameter int DIV_LATENCY = 6,
  parameter int CL_ADDR_W   = 42,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic reset,
  divider_batch_engine_if.master bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, FEED,
    DRAIN, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t state, state_nx;

  logic [CL_ADDR_W-1:0] in_base_q, out_base_q;
  logic [CNT_W-1:0]     num_q, line_idx, div0_cnt;
  logic [511:0]         line_q, line_out;
  logic [LW-1:0]        lane;
  logic [LW:0]          got, got_nx;
  logic [DATA_LEN-1:0]  slot [LANES];
  logic [LANES-1:0]     mask;
  logic                 done_q;
  logic                 rd_v, wr_v, iv;

  logic [DIV_LATENCY-1:0] tv, tz;
  logic [LW-1:0]          tl [DIV_LATENCY];
  logic                   tail_v, tail_z;
  logic [LW-1:0]          tail_l;

  logic [DATA_LEN-1:0] a_arr [LANES];
  logic [DATA_LEN-1:0] b_arr [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign a_arr[k] = line_q[2*k*DATA_LEN +: DATA_LEN];
    assign b_arr[k] = line_q[(2*k+1)*DATA_LEN +: DATA_LEN];
  end

  assign tail_v = tv[DIV_LATENCY-1];
  assign tail_z = tz[DIV_LATENCY-1];
  assign tail_l = tl[DIV_LATENCY-1];
  assign got_nx = got + {{LW{1'b0}}, tail_v};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_v     = 1'b0;
    wr_v     = 1'b0;
    iv       = 1'b0;
    unique case (state)
      IDLE:
        if (bus.start)
          state_nx = (bus.num_lines == '0) ? DONE : RD_REQ;
      RD_REQ:
        if (!bus.rd_req_almost_full) begin
          rd_v     = 1'b1;
          state_nx = RD_WAIT;
        end
      RD_WAIT:
        if (bus.rd_rsp_valid) state_nx = FEED;
      FEED: begin
        iv = 1'b1;
        if (lane == LAST) state_nx = DRAIN;
      end
      DRAIN:
        if (got_nx == (LW+1)'(LANES)) state_nx = WR_REQ;
      WR_REQ:
        if (!bus.wr_req_almost_full) begin
          wr_v     = 1'b1;
          state_nx = WR_WAIT;
        end
      WR_WAIT:
        if (bus.wr_rsp_valid)
          state_nx = (line_idx + 1'b1 == num_q) ? DONE : RD_REQ;
      DONE:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_base_q  <= '0;
      out_base_q <= '0;
      num_q      <= '0;
      line_idx   <= '0;
      div0_cnt   <= '0;
      line_q     <= '0;
      lane       <= '0;
      got        <= '0;
      mask       <= '0;
      done_q     <= 1'b0;
      tv         <= '0;
      tz         <= '0;
      for (int i = 0; i < DIV_LATENCY; i++) tl[i] <= '0;
      for (int k = 0; k < LANES; k++) slot[k] <= '0;
    end else begin
      done_q <= (state == DONE);
      if (state == IDLE && bus.start) begin
        in_base_q  <= bus.in_base;
        out_base_q <= bus.out_base;
        num_q      <= bus.num_lines;
        line_idx   <= '0;
        div0_cnt   <= '0;
      end
      if (state == RD_WAIT && bus.rd_rsp_valid) line_q <= bus.rd_rsp_data;
      if (iv) lane <= (lane == LAST) ? '0 : lane + 1'b1;
      tv[0] <= iv;
      tz[0] <= iv && (b_arr[lane] == '0);
      tl[0] <= lane;
      for (int i = 1; i < DIV_LATENCY; i++) begin
        tv[i] <= tv[i-1];
        tz[i] <= tz[i-1];
        tl[i] <= tl[i-1];
      end
      if (tail_v) begin
        got <= got_nx;
        slot[tail_l] <= tail_z ? '1 : bus.div_result;
        if (tail_z) begin
          mask[tail_l] <= 1'b1;
          div0_cnt     <= div0_cnt + 1'b1;
        end
      end
      if (state == WR_WAIT && bus.wr_rsp_valid) begin
        line_idx <= line_idx + 1'b1;
        got      <= '0;
        mask     <= '0;
        for (int k = 0; k < LANES; k++) slot[k] <= '0;
      end
    end
  end

  always_comb begin
    line_out           = '0;
    line_out[7:0]      = 8'h01;
    line_out[16 +: LANES] = mask;
    line_out[63:32]    = 32'(line_idx);
    for (int k = 0; k < LANES; k++)
      line_out[64 + k*DATA_LEN +: DATA_LEN] = slot[k];
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;
  assign bus.div0_count   = div0_cnt;
  assign bus.rd_req_valid = rd_v;
  assign bus.rd_req_addr  = in_base_q + CL_ADDR_W'(line_idx);
  assign bus.wr_req_valid = wr_v;
  assign bus.wr_req_addr  = out_base_q + CL_ADDR_W'(line_idx);
  assign bus.wr_req_data  = wr_v ? line_out : '0;
  assign bus.div_in_valid = iv;
  assign bus.div_a        = iv ? a_arr[lane] : '0;
  assign bus.div_b        = iv ? b_arr[lane] : '0;
endmodule

// File: tb/tb_divider_batch_engine.sv
// Directed bench for divider_batch_engine with a pipelined divider model
// and a hand-driven memory channel.
module tb_divider_batch_engine;
  localparam int DL  = 32;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  divider_batch_engine_if #(.DATA_LEN(32), .CL_ADDR_W(42), .CNT_W(16)) bus ();

  divider_batch_engine #(
    .DATA_LEN(32), .LANES(8), .DIV_LATENCY(LAT),
    .CL_ADDR_W(42), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  logic [DL-1:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= !bus.div_in_valid ? 32'h0 :
                (bus.div_b == 0) ? 32'h0BAD0BAD : bus.div_a / bus.div_b;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.div_result = dpipe[LAT-1];

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_in(input int a0, input int astep,
                                         input int b);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) begin
      l[64*k +: 32]      = 32'(a0 + astep*k);
      l[64*k + 32 +: 32] = 32'(b);
    end
    return l;
  endfunction

  function automatic logic [511:0] mk_out(input logic [31:0] idx,
                                          input logic [7:0] msk,
                                          input logic [255:0] res);
    logic [511:0] l;
    l = '0;
    l[7:0]    = 8'h01;
    l[23:16]  = msk;
    l[63:32]  = idx;
    l[319:64] = res;
    return l;
  endfunction

  task automatic start_batch(input logic [41:0] ib, input logic [41:0] ob,
                             input logic [15:0] n);
    bus.in_base = ib;
    bus.out_base = ob;
    bus.num_lines = n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_line(input logic [41:0] rd_a, input logic [511:0] rdata,
                          input logic [41:0] wr_a, input logic [511:0] wexp,
                          input int hold_wr);
    int n;
    int extra;
    int leak;
    n = 0;
    while (!bus.rd_req_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rd_seen", bus.rd_req_valid, 1'b1);
    chk("rd_addr", bus.rd_req_addr, rd_a);
    @(negedge clk);
    chk("rd_single", bus.rd_req_valid, 1'b0);
    repeat (2) @(negedge clk);
    bus.rd_rsp_data = rdata;
    bus.rd_rsp_valid = 1'b1;
    if (hold_wr > 0) bus.wr_req_almost_full = 1'b1;
    @(negedge clk);
    bus.rd_rsp_valid = 1'b0;
    chk("feed_lane0", {bus.div_in_valid, bus.div_a, bus.div_b},
        {1'b1, rdata[31:0], rdata[63:32]});
    extra = 0;
    if (hold_wr > 0) begin
      leak = 0;
      repeat (hold_wr) begin
        @(negedge clk);
        if (bus.wr_req_valid) leak++;
        if (bus.rd_req_valid) extra++;
      end
      chk("wr_hold", leak, 0);
      bus.wr_req_almost_full = 1'b0;
      #1;
    end
    n = 0;
    while (!bus.wr_req_valid && n < 100) begin
      @(negedge clk);
      if (bus.rd_req_valid) extra++;
      n++;
    end
    chk("wr_seen", bus.wr_req_valid, 1'b1);
    if (hold_wr == 0) chk("wr_latency", n, 14);
    chk("wr_addr", bus.wr_req_addr, wr_a);
    chk("wr_data", bus.wr_req_data, wexp);
    @(negedge clk);
    chk("wr_single", bus.wr_req_valid, 1'b0);
    @(negedge clk);
    if (bus.rd_req_valid) extra++;
    bus.wr_rsp_valid = 1'b1;
    @(negedge clk);
    bus.wr_rsp_valid = 1'b0;
    chk("alternate", extra, 0);
  endtask

  task automatic check_done();
    chk("done_early", bus.done, 1'b0);
    @(negedge clk);
    chk("done_pulse", {bus.done, bus.busy}, 2'b10);
    @(negedge clk);
    chk("done_end", {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin : stim
    logic [511:0] l1;
    logic [511:0] o1;
    logic [511:0] l2;
    logic [255:0] res;
    int bad;

    bus.start = 0;
    bus.in_base = '0;
    bus.out_base = '0;
    bus.num_lines = '0;
    bus.rd_req_almost_full = 0;
    bus.rd_rsp_valid = 0;
    bus.rd_rsp_data = '0;
    bus.wr_req_almost_full = 0;
    bus.wr_rsp_valid = 0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {bus.busy, bus.done, bus.rd_req_valid,
                    bus.wr_req_valid, bus.div_in_valid}, 5'b0);
    chk("rst_data", {bus.div_a, bus.div_b, bus.div0_count,
                     bus.rd_req_addr, bus.wr_req_addr}, '0);
    chk("rst_wdata", bus.wr_req_data, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle", bus.busy, 1'b0);

    // single line, quotients of 100..107 by 7
    l1 = mk_in(100, 1, 7);
    o1 = mk_out(32'd0, 8'h00,
                {32'd15, 32'd15, 32'd15, 32'd14,
                 32'd14, 32'd14, 32'd14, 32'd14});
    start_batch(42'h40, 42'h80, 16'd1);
    chk("busy", bus.busy, 1'b1);
    run_line(42'h40, l1, 42'h80, o1, 0);
    check_done();
    chk("div0_none", bus.div0_count, 16'd0);

    // zero divisor on lane 3
    l2 = mk_in(9, 0, 3);
    l2[255:224] = 32'h0;
    start_batch(42'h10, 42'h20, 16'd1);
    run_line(42'h10, l2, 42'h20,
             mk_out(32'd0, 8'h08,
                    {32'd3, 32'd3, 32'd3, 32'd3,
                     32'hFFFF_FFFF, 32'd3, 32'd3, 32'd3}), 0);
    check_done();
    chk("div0_one", bus.div0_count, 16'd1);

    // empty batch, second start while busy ignored
    bus.num_lines = 16'd0;
    bus.start = 1'b1;
    @(negedge clk);
    chk("zero_t1", {bus.busy, bus.done, bus.rd_req_valid}, 3'b100);
    chk("div0_clear", bus.div0_count, 16'd0);
    bus.num_lines = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zero_t2", {bus.busy, bus.done, bus.rd_req_valid}, 3'b010);
    @(negedge clk);
    chk("zero_t3", {bus.busy, bus.done, bus.rd_req_valid}, 3'b000);

    // three lines, strictly alternating
    start_batch(42'h100, 42'h200, 16'd3);
    for (int i = 0; i < 3; i++) begin
      res = '0;
      for (int k = 0; k < 8; k++) res[32*k +: 32] = 32'(10*(i+1) + k);
      run_line(42'h100 + 42'(i), mk_in(50*(i+1), 5, 5),
               42'h200 + 42'(i), mk_out(32'(i), 8'h00, res), 0);
    end
    check_done();

    // read and write backpressure
    bus.rd_req_almost_full = 1'b1;
    start_batch(42'h40, 42'h80, 16'd1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rd_req_valid) bad++;
    end
    chk("rd_hold", bad, 0);
    bus.rd_req_almost_full = 1'b0;
    #1;
    run_line(42'h40, l1, 42'h80, o1, 25);
    check_done();

    // reset while feeding the divider
    start_batch(42'h300, 42'h380, 16'd1);
    bad = 0;
    while (!bus.rd_req_valid && bad < 60) begin
      @(negedge clk);
      bad++;
    end
    chk("rst_rd_seen", bus.rd_req_valid, 1'b1);
    repeat (2) @(negedge clk);
    bus.rd_rsp_data = l2;
    bus.rd_rsp_valid = 1'b1;
    @(negedge clk);
    bus.rd_rsp_valid = 1'b0;
    chk("rst_in_feed", bus.div_in_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ctl", {bus.busy, bus.done, bus.rd_req_valid,
                      bus.wr_req_valid, bus.div_in_valid}, 5'b0);
    chk("abort_data", {bus.div_a, bus.div_b, bus.div0_count,
                       bus.rd_req_addr, bus.wr_req_addr}, '0);
    reset = 1'b0;
    bus.rd_rsp_valid = 1'b1;
    @(negedge clk);
    bus.rd_rsp_valid = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.wr_req_valid || bus.div0_count != 0)
        bad++;
    end
    chk("abort_quiet", bad, 0);

    start_batch(42'h40, 42'h80, 16'd1);
    run_line(42'h40, l1, 42'h80, o1, 0);
    check_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
